// File: rtl/mem_wb_stage_p_if.sv
// MEM/WB stage bus: pipeline control, EXE/MEM entry inputs and write-back outputs.
// in_signed exists only when MEM_WB_SIGNED_LOAD_EN is defined.
interface mem_wb_stage_p_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic                  stall;
   logic                  flush;
   logic                  in_valid;
   logic                  in_reg_write;
   logic                  in_mem_or_reg;
   logic [1:0]            in_size;
`ifdef MEM_WB_SIGNED_LOAD_EN
   logic                  in_signed;
`endif
   logic [OFF_W-1:0]      in_byte_off;
   logic                  in_hilo_write;
   logic                  in_write_float;
   logic [DATA_W-1:0]     in_alu_result;
   logic [DATA_W-1:0]     in_alu_result2;
   logic [DATA_W-1:0]     in_mem_rdata;
   logic [REG_ADDR_W-1:0] in_wr_addr;

   logic                  out_valid;
   logic                  out_reg_write;
   logic                  out_hilo_write;
   logic                  out_write_float;
   logic [DATA_W-1:0]     out_wr_data;
   logic [DATA_W-1:0]     out_wr_data2;
   logic [REG_ADDR_W-1:0] out_wr_addr;
   logic                  misalign_err;
   logic [CNT_W-1:0]      retire_cnt;

   modport master (
      output stall, flush, in_valid, in_reg_write, in_mem_or_reg, in_size,
`ifdef MEM_WB_SIGNED_LOAD_EN
      output in_signed,
`endif
      output in_byte_off, in_hilo_write, in_write_float, in_alu_result,
      output in_alu_result2, in_mem_rdata, in_wr_addr,
      input  out_valid, out_reg_write, out_hilo_write, out_write_float,
      input  out_wr_data, out_wr_data2, out_wr_addr, misalign_err, retire_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_reg_write, in_mem_or_reg, in_size,
`ifdef MEM_WB_SIGNED_LOAD_EN
      input  in_signed,
`endif
      input  in_byte_off, in_hilo_write, in_write_float, in_alu_result,
      input  in_alu_result2, in_mem_rdata, in_wr_addr,
      output out_valid, out_reg_write, out_hilo_write, out_write_float,
      output out_wr_data, out_wr_data2, out_wr_addr, misalign_err, retire_cnt
   );
endinterface

// File: rtl/mem_wb_stage_p.sv
// MEM/WB pipeline register (falling-edge) with lane extraction, misalignment suppression
// and retire counter. Define MEM_WB_SIGNED_LOAD_EN to enable sign-extending loads.
module mem_wb_stage_p #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 16
) (
   input logic             clk,
   input logic             rst_n,
   mem_wb_stage_p_if.slave io
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   typedef enum logic [1:0] {
      SZ_FULL = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } size_e;

   size_e             size;
   logic [OFF_W-1:0]  off;
   logic [OFF_W-1:0]  off_h;
   logic [OFF_W-1:0]  off_w;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       lane_w;
   logic              sgn;
   logic              misaligned;
   logic              mis;
   logic [DATA_W-1:0] load_data;

   logic                  valid_q, valid_d;
   logic                  rw_q, rw_d;
   logic                  hw_q, hw_d;
   logic                  fw_q, fw_d;
   logic                  mis_q, mis_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic [DATA_W-1:0]     data2_q, data2_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign size = size_e'(io.in_size);
   assign off  = io.in_byte_off;

   // Half/word lanes start at the offset rounded down; for DATA_W=32 off_w is always 0.
   assign off_h  = off & ~OFF_W'(1);
   assign off_w  = off & ~OFF_W'(3);
   assign lane_b = io.in_mem_rdata[{off,   3'b000} +: 8];
   assign lane_h = io.in_mem_rdata[{off_h, 3'b000} +: 16];
   assign lane_w = io.in_mem_rdata[{off_w, 3'b000} +: 32];

`ifdef MEM_WB_SIGNED_LOAD_EN
   assign sgn = io.in_signed;
`else
   assign sgn = 1'b0;
`endif

   always_comb begin
      load_data  = io.in_mem_rdata;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            load_data = sgn ? DATA_W'($signed(lane_b)) : DATA_W'(lane_b);
         end
         SZ_HALF: begin
            load_data  = sgn ? DATA_W'($signed(lane_h)) : DATA_W'(lane_h);
            misaligned = off[0];
         end
         SZ_WORD: begin
            load_data  = sgn ? DATA_W'($signed(lane_w)) : DATA_W'(lane_w);
            misaligned = |off[1:0];
         end
         default: begin
            load_data  = io.in_mem_rdata;
            misaligned = |off;
         end
      endcase
   end

   assign mis = io.in_valid & ~io.in_mem_or_reg & misaligned;

   always_comb begin
      valid_d = valid_q;
      rw_d    = rw_q;
      hw_d    = hw_q;
      fw_d    = fw_q;
      mis_d   = mis_q;
      data_d  = data_q;
      data2_d = data2_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      if (io.flush) begin
         valid_d = 1'b0;
         rw_d    = 1'b0;
         hw_d    = 1'b0;
         fw_d    = 1'b0;
         mis_d   = 1'b0;
         data_d  = '0;
         data2_d = '0;
         addr_d  = '0;
      end else if (io.stall) begin
         mis_d = 1'b0;
      end else begin
         valid_d = io.in_valid;
         rw_d    = io.in_valid & io.in_reg_write & ~mis;
         hw_d    = io.in_valid & io.in_hilo_write & ~mis;
         fw_d    = io.in_valid & io.in_write_float & ~mis;
         mis_d   = mis;
         data_d  = io.in_mem_or_reg ? io.in_alu_result : load_data;
         data2_d = io.in_alu_result2;
         addr_d  = io.in_wr_addr;
         if (io.in_valid && !mis) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rw_q    <= 1'b0;
         hw_q    <= 1'b0;
         fw_q    <= 1'b0;
         mis_q   <= 1'b0;
         data_q  <= '0;
         data2_q <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rw_q    <= rw_d;
         hw_q    <= hw_d;
         fw_q    <= fw_d;
         mis_q   <= mis_d;
         data_q  <= data_d;
         data2_q <= data2_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io.out_valid       = valid_q;
   assign io.out_reg_write   = rw_q;
   assign io.out_hilo_write  = hw_q;
   assign io.out_write_float = fw_q;
   assign io.misalign_err    = mis_q;
   assign io.out_wr_data     = data_q;
   assign io.out_wr_data2    = data2_q;
   assign io.out_wr_addr     = addr_q;
   assign io.retire_cnt      = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage_p.sv
// Bench for mem_wb_stage_p: 32- and 64-bit instances (CNT_W=4) against a behavioural model.
module tb_mem_wb_stage_p;
   logic clk;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   logic        stall, flush, iv, irw, imr, ihw, ifw, isg;
   logic [1:0]  isz;
   logic [2:0]  ioff;
   logic [63:0] alu, alu2, rd;
   logic [4:0]  wa;

   typedef struct {
      logic        v, rw, hw, fw, mis;
      logic [63:0] d, d2;
      logic [4:0]  a;
      int unsigned cnt;
   } st_t;

   st_t m32, m64;

   mem_wb_stage_p_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) b32 ();
   mem_wb_stage_p_if #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) b64 ();

   mem_wb_stage_p #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .io(b32.slave));
   mem_wb_stage_p #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .io(b64.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ext(logic [63:0] val, int unsigned bits);
      logic [63:0] r;
      r = val;
`ifdef MEM_WB_SIGNED_LOAD_EN
      if (isg && val[bits-1]) r = val | (~64'd0 << bits);
`endif
      return r;
   endfunction

   // Reference: priority reset > flush > stall > capture, written from the rules directly.
   function automatic st_t model(st_t s, int unsigned dw);
      st_t n;
      logic [63:0] dmask, lane;
      int unsigned o;
      logic badal, mis;
      n = s;
      dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      o = int'(ioff) % (dw / 8);
      if (!rst_n) begin
         n = '{default: 0};
      end else if (flush) begin
         n = '{default: 0};
         n.cnt = s.cnt;
      end else if (stall) begin
         n.mis = 1'b0;
      end else begin
         case (isz)
            2'b01: begin lane = ext((rd >> (8 * o)) & 64'hFF, 8); badal = 1'b0; end
            2'b10: begin lane = ext((rd >> (16 * (o / 2))) & 64'hFFFF, 16); badal = (o % 2) != 0; end
            2'b11: begin lane = ext((rd >> (32 * (o / 4))) & 64'hFFFF_FFFF, 32); badal = (o % 4) != 0; end
            default: begin lane = rd; badal = (o != 0); end
         endcase
         mis   = iv && !imr && badal;
         n.v   = iv;
         n.rw  = iv && irw && !mis;
         n.hw  = iv && ihw && !mis;
         n.fw  = iv && ifw && !mis;
         n.mis = mis;
         n.d   = (imr ? alu : lane) & dmask;
         n.d2  = alu2 & dmask;
         n.a   = wa;
         if (iv && !mis) n.cnt = (s.cnt + 1) % 16;
      end
      return n;
   endfunction

   function automatic logic [141:0] pk_m(st_t s);
      return {s.v, s.rw, s.hw, s.fw, s.mis, s.d, s.d2, s.a, 4'(s.cnt)};
   endfunction

   function automatic logic [141:0] pk_32();
      return {b32.out_valid, b32.out_reg_write, b32.out_hilo_write, b32.out_write_float,
              b32.misalign_err, 32'd0, b32.out_wr_data, 32'd0, b32.out_wr_data2,
              b32.out_wr_addr, b32.retire_cnt};
   endfunction

   function automatic logic [141:0] pk_64();
      return {b64.out_valid, b64.out_reg_write, b64.out_hilo_write, b64.out_write_float,
              b64.misalign_err, b64.out_wr_data, b64.out_wr_data2,
              b64.out_wr_addr, b64.retire_cnt};
   endfunction

   task automatic drive();
      b32.stall = stall;          b64.stall = stall;
      b32.flush = flush;          b64.flush = flush;
      b32.in_valid = iv;          b64.in_valid = iv;
      b32.in_reg_write = irw;     b64.in_reg_write = irw;
      b32.in_mem_or_reg = imr;    b64.in_mem_or_reg = imr;
      b32.in_size = isz;          b64.in_size = isz;
      b32.in_byte_off = ioff[1:0]; b64.in_byte_off = ioff;
      b32.in_hilo_write = ihw;    b64.in_hilo_write = ihw;
      b32.in_write_float = ifw;   b64.in_write_float = ifw;
      b32.in_alu_result = alu[31:0];   b64.in_alu_result = alu;
      b32.in_alu_result2 = alu2[31:0]; b64.in_alu_result2 = alu2;
      b32.in_mem_rdata = rd[31:0];     b64.in_mem_rdata = rd;
      b32.in_wr_addr = wa;        b64.in_wr_addr = wa;
`ifdef MEM_WB_SIGNED_LOAD_EN
      b32.in_signed = isg;        b64.in_signed = isg;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      drive();
      @(negedge clk);
      m32 = model(m32, 32);
      m64 = model(m64, 64);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; iv = 0; irw = 0; imr = 0; ihw = 0; ifw = 0; isg = 0;
      isz = 2'b00; ioff = 0; alu = 0; alu2 = 0; rd = 0; wa = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      stall = 0; flush = 0; iv = 1; irw = 1; imr = 1; ihw = 1; ifw = 1;
      alu = {$urandom, $urandom}; alu2 = {$urandom, $urandom}; wa = 5'd17;
      repeat (2) tick();
      total++;
      if (pk_32() !== '0) begin bad++; $display("FAIL reset32 got=%h exp=0", pk_32()); end
      total++;
      if (pk_64() !== '0) begin bad++; $display("FAIL reset64 got=%h exp=0", pk_64()); end
   endtask

   task automatic test_load();
      rst_n = 1; idle_inputs();
      iv = 1; imr = 1; irw = 1; alu = 64'h1234_5678; wa = 5'd9;
      tick();
      total++;
      if ({b32.out_wr_data, b32.out_wr_addr, b32.out_reg_write, b32.retire_cnt} !==
          {32'h1234_5678, 5'd9, 1'b1, 4'd1}) begin
         bad++;
         $display("FAIL load32 got data=%h addr=%0d rw=%b cnt=%0d exp 12345678/9/1/1",
                  b32.out_wr_data, b32.out_wr_addr, b32.out_reg_write, b32.retire_cnt);
      end
      total++;
      if (pk_64() !== pk_m(m64)) begin bad++; $display("FAIL load64 got=%h exp=%h", pk_64(), pk_m(m64)); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] exp_b [4];
      exp_b[0] = 32'h01; exp_b[1] = 32'h7F; exp_b[2] = 32'hFF; exp_b[3] = 32'h80;
      idle_inputs();
      iv = 1; irw = 1; imr = 0; isz = 2'b01; rd = 64'h0000_0000_80FF_7F01;
      for (int i = 0; i < 4; i++) begin
         ioff = 3'(i);
         tick();
         total++;
         if (b32.out_wr_data !== exp_b[i]) begin
            bad++; $display("FAIL byte32 off=%0d got=%h exp=%h", i, b32.out_wr_data, exp_b[i]);
         end
         total++;
         if (b64.out_wr_data !== {32'd0, exp_b[i]}) begin
            bad++; $display("FAIL byte64 off=%0d got=%h exp=%h", i, b64.out_wr_data, exp_b[i]);
         end
      end
`ifdef MEM_WB_SIGNED_LOAD_EN
      isg = 1; ioff = 3;
      tick();
      total++;
      if (b32.out_wr_data !== 32'hFFFF_FF80) begin
         bad++; $display("FAIL sbyte32 got=%h exp=ffffff80", b32.out_wr_data);
      end
      total++;
      if (b64.out_wr_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
         bad++; $display("FAIL sbyte64 got=%h exp=ffffffffffffff80", b64.out_wr_data);
      end
      isg = 0;
`endif
   endtask

   task automatic test_misalign();
      logic [3:0] c0;
      idle_inputs();
      c0 = b32.retire_cnt;
      iv = 1; irw = 1; imr = 0; isz = 2'b10; ioff = 1; rd = {$urandom, $urandom};
      tick();
      total++;
      if ({b32.out_reg_write, b32.out_valid, b32.misalign_err, b32.retire_cnt} !== {3'b011, c0}) begin
         bad++;
         $display("FAIL misalign32 got rw=%b v=%b err=%b cnt=%0d exp 0/1/1/%0d",
                  b32.out_reg_write, b32.out_valid, b32.misalign_err, b32.retire_cnt, c0);
      end
      total++;
      if (pk_64() !== pk_m(m64)) begin bad++; $display("FAIL misalign64 got=%h exp=%h", pk_64(), pk_m(m64)); end
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({b32.misalign_err, b32.out_valid, b32.retire_cnt} !== {2'b01, c0}) begin
            bad++;
            $display("FAIL misalign_stall32 edge=%0d got err=%b v=%b cnt=%0d exp 0/1/%0d",
                     i, b32.misalign_err, b32.out_valid, b32.retire_cnt, c0);
         end
         total++;
         if (b64.misalign_err !== 1'b0) begin
            bad++; $display("FAIL misalign_stall64 edge=%0d got=%b exp=0", i, b64.misalign_err);
         end
      end
      stall = 0;
   endtask

   task automatic test_stall_flush();
      logic [141:0] held32, held64;
      logic [3:0]   c0;
      idle_inputs();
      iv = 1; imr = 1; irw = 1; ihw = 1; ifw = 1;
      alu = {$urandom, $urandom}; alu2 = {$urandom, $urandom}; wa = 5'd21;
      tick();
      held32 = pk_32(); held64 = pk_64(); c0 = b32.retire_cnt;
      total++;
      if (held32 !== pk_m(m32)) begin bad++; $display("FAIL capture32 got=%h exp=%h", held32, pk_m(m32)); end
      stall = 1; alu = {$urandom, $urandom}; alu2 = ~alu; wa = 5'd3; irw = 0;
      tick();
      total++;
      if (pk_32() !== held32) begin bad++; $display("FAIL stall_hold32 got=%h exp=%h", pk_32(), held32); end
      total++;
      if (pk_64() !== held64) begin bad++; $display("FAIL stall_hold64 got=%h exp=%h", pk_64(), held64); end
      flush = 1;
      tick();
      total++;
      if (pk_32() !== {5'b0, 64'd0, 64'd0, 5'd0, c0}) begin
         bad++; $display("FAIL flush32 got=%h exp cnt=%0d rest 0", pk_32(), c0);
      end
      total++;
      if (pk_64() !== pk_m(m64)) begin bad++; $display("FAIL flush64 got=%h exp=%h", pk_64(), pk_m(m64)); end
      flush = 0; stall = 0;
   endtask

   task automatic test_counter_wrap();
      idle_inputs();
      rst_n = 0;
      tick();
      rst_n = 1; iv = 1; imr = 1; irw = 1;
      for (int i = 0; i < 17; i++) begin
         alu = {$urandom, $urandom};
         tick();
      end
      total++;
      if (b32.retire_cnt !== 4'd1) begin bad++; $display("FAIL wrap32 got=%0d exp=1", b32.retire_cnt); end
      total++;
      if (b64.retire_cnt !== 4'd1) begin bad++; $display("FAIL wrap64 got=%0d exp=1", b64.retire_cnt); end
      repeat (5) tick();
      stall = 1; flush = 1; rst_n = 0;
      tick();
      total++;
      if (pk_32() !== '0) begin bad++; $display("FAIL midreset32 got=%h exp=0", pk_32()); end
      total++;
      if (pk_64() !== '0) begin bad++; $display("FAIL midreset64 got=%h exp=0", pk_64()); end
      rst_n = 1; stall = 0; flush = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 7) == 0);
         iv = ($urandom_range(0, 4) != 0);
         irw = 1'($urandom); imr = 1'($urandom); ihw = 1'($urandom);
         ifw = 1'($urandom); isg = 1'($urandom);
         isz = 2'($urandom); ioff = 3'($urandom);
         alu = {$urandom, $urandom}; alu2 = {$urandom, $urandom};
         rd = {$urandom, $urandom}; wa = 5'($urandom);
         tick();
         total++;
         if (pk_32() !== pk_m(m32)) begin
            bad++; $display("FAIL rand32 cyc=%0d got=%h exp=%h", i, pk_32(), pk_m(m32));
         end
         total++;
         if (pk_64() !== pk_m(m64)) begin
            bad++; $display("FAIL rand64 cyc=%0d got=%h exp=%h", i, pk_64(), pk_m(m64));
         end
      end
   endtask

   initial begin
      m32 = '{default: 0};
      m64 = '{default: 0};
      rst_n = 0;
      idle_inputs();
      drive();
      test_reset();
      test_load();
      test_byte_lanes();
      test_misalign();
      test_stall_flush();
      test_counter_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_wb_stage_p.md
Name: mem_wb_stage_p

Overview:
- Parametrised MEM/WB pipeline register for the 5-stage MIPS pipeline, between the data-memory stage and the register-file/HI-LO/FP write-back ports.
- Adds several capabilities over a plain MEM/WB register:
  - stall and flush;
  - per-entry valid bit;
  - byte/half/word/full lane extraction using address offset;
  - misalignment detection with write suppression;
  - retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 16, retire counter width.
- OFF_W (derived, not overridable), log2(DATA_W/8), byte-offset width.

Ports:
- clk  in  1  pipeline clock; all state updates on falling edge.
- rst_n  in  1  synchronous active-low reset, sampled on the falling edge of clk.
- stall  in  1  hold all registered state.
- flush  in  1  insert bubble.
- in_valid  in  1  EXE/MEM entry valid.
- in_reg_write  in  1  GPR write request.
- in_mem_or_reg  in  1  1 = ALU result, 0 = memory read data.
- in_size  in  2  load size: 00 full DATA_W, 01 byte, 10 half, 11 word (32b).
- in_byte_off  in  OFF_W  low address bits of load.
- in_hilo_write  in  1  HI/LO write request.
- in_write_float  in  1  FP register write request.
- in_alu_result  in  DATA_W  primary ALU result.
- in_alu_result2  in  DATA_W  secondary result (HI).
- in_mem_rdata  in  DATA_W  data-memory read word.
- in_wr_addr  in  REG_ADDR_W  destination register.
- out_valid  out  1  WB entry valid.
- out_reg_write  out  1  qualified GPR write enable.
- out_hilo_write  out  1  qualified HI/LO write enable.
- out_write_float  out  1  qualified FP write enable.
- out_wr_data  out  DATA_W  write-back data.
- out_wr_data2  out  DATA_W  secondary write-back data.
- out_wr_addr  out  REG_ADDR_W  destination register.
- misalign_err  out  1  one-cycle pulse: misaligned load captured.
- retire_cnt  out  CNT_W  count of retired valid entries.

Behaviour:
- Priority at each falling edge: reset > flush > stall > capture. Latency is one cycle, from the input sampled at edge N to the output valid after edge N.
- Reset (rst_n=0):
  - every output = 0, including out_wr_data, out_wr_data2, out_wr_addr and retire_cnt.
  - Reset asserted mid-stall or mid-flush still clears everything.
- Flush:
  - out_valid, out_reg_write, out_hilo_write, out_write_float and misalign_err = 0.
  - out_wr_data, out_wr_data2 and out_wr_addr = 0.
  - retire_cnt holds.
- Stall (no flush):
  - all outputs hold, except misalign_err, which is forced to 0 so it stays a single pulse.
  - retire_cnt holds.
- Capture:
  - out_valid = in_valid.
  - mis = in_valid & ~in_mem_or_reg & misaligned, where misaligned means:
    - half with in_byte_off[0] != 0;
    - word with in_byte_off[1:0] != 0;
    - full with in_byte_off != 0;
    - byte is never misaligned.
  - out_reg_write = in_valid & in_reg_write & ~mis.
  - out_hilo_write = in_valid & in_hilo_write & ~mis.
  - out_write_float = in_valid & in_write_float & ~mis.
  - misalign_err = mis.
  - out_wr_addr = in_wr_addr.
  - out_wr_data2 = in_alu_result2.
- Write data on capture:
  - if in_mem_or_reg=1: out_wr_data = in_alu_result.
  - else, little-endian lane select on in_mem_rdata:
    - byte = bits [8*off +: 8];
    - half = bits [16*off[OFF_W-1:1] +: 16];
    - word = bits [32*off[OFF_W-1:2] +: 32] (for DATA_W=32 this is the full word);
    - full = in_mem_rdata;
    - the selected lane is extended to DATA_W per the sign rule under Optional Feature.
  - Misaligned loads still capture the lane data; only the write enables are suppressed.
- retire_cnt increments by 1 on a capture with in_valid=1 and mis=0. It wraps from 2^CNT_W-1 to 0 with no saturation or flag.

Optional Feature:
- Macro MEM_WB_SIGNED_LOAD_EN.
- When defined:
  - adds input port in_signed (1 bit, placed after in_size).
  - byte, half and word (when DATA_W=64) lanes sign-extend when in_signed=1 and zero-extend when in_signed=0.
- When undefined:
  - no in_signed port.
  - all sub-width lanes zero-extend (LBU/LHU semantics only).

Test Plan:
- Reset then load: with rst_n=0 for 2 edges, all outputs = 0. Then release and capture in_valid=1, in_mem_or_reg=1, in_alu_result=0x1234_5678, in_wr_addr=9, in_reg_write=1 → after 1 edge, out_wr_data=0x12345678, out_wr_addr=9, out_reg_write=1, retire_cnt=1.
- Byte lanes: in_mem_rdata=0x80FF_7F01, size=01, off=0..3 → out_wr_data = 0x01, 0x7F, 0xFF, 0x80 (zero-extended). With the macro defined and in_signed=1, off=3 → 0xFFFF_FF80.
- Misaligned: size=10, off=1, in_reg_write=1 → out_reg_write=0, out_valid=1, misalign_err=1 for exactly one cycle, retire_cnt unchanged. The same entry with stall held for 3 edges keeps misalign_err=0 after the first edge.
- Stall/flush precedence: stall=1 with new inputs → outputs unchanged. Then stall=1 and flush=1 together → out_valid=0, all enables 0, out_wr_data=0, retire_cnt held.
- Counter wrap: CNT_W=4, 17 valid aligned captures → retire_cnt reads 1. Asserting rst_n=0 mid-sequence → 0 on the next falling edge.
